// File: rtl/ltc2324_pkg.sv
// Shared types and constants for the LTC2324 acquisition path.
package ltc2324_pkg;

  // Sequencer phases within one conversion frame
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CNV       = 3'd1,
    ST_CONV_WAIT = 3'd2,
    ST_READ      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_LATCH     = 3'd5,
    ST_HOLD      = 3'd6
  } seq_state_e;

  // Default frame phase lengths
  localparam int unsigned DEF_CNV_HIGH_CYC = 3;
  localparam int unsigned DEF_CONV_CYC     = 45;
  localparam int unsigned DEF_SCK_BITS     = 16;
  localparam int unsigned DEF_DRAIN_CYC    = 4;

  // Channel codes carried in the deserializer words
  localparam logic [2:0] CH_CODE_1 = 3'd1;
  localparam logic [2:0] CH_CODE_2 = 3'd2;
  localparam logic [2:0] CH_CODE_3 = 3'd3;
  localparam logic [2:0] CH_CODE_4 = 3'd4;

  // Shortest frame that fits every phase plus the latch cycle
  function automatic int unsigned min_frame(input int unsigned cnv_high,
                                            input int unsigned conv,
                                            input int unsigned sck,
                                            input int unsigned drain);
    return cnv_high + conv + sck + drain + 1;
  endfunction

endpackage

// File: rtl/ltc2324_frame_timer.sv
// Frame period counter: holds the clamped period P, flags the last cycle
// of each frame so the next one starts exactly P cycles after the previous.
module ltc2324_frame_timer
  import ltc2324_pkg::*;
#(
  parameter int unsigned PERIOD_W  = 16,
  parameter int unsigned MIN_FRAME = min_frame(DEF_CNV_HIGH_CYC, DEF_CONV_CYC,
                                               DEF_SCK_BITS, DEF_DRAIN_CYC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                halt,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                next_frame_c,
  output logic                cfg_err
);

  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                cfg_err_q, cfg_err_d;
  logic                clamp_c;

  // Period latch on load, free-running wrap counter while running
  always_comb begin
    per_d        = per_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    cfg_err_d    = cfg_err_q;
    clamp_c      = (cfg_period < PERIOD_W'(MIN_FRAME));
    next_frame_c = run_q && (cnt_q == (per_q - PERIOD_W'(1)));
    if (load) begin
      per_d     = clamp_c ? PERIOD_W'(MIN_FRAME) : cfg_period;
      cnt_d     = '0;
      run_d     = 1'b1;
      cfg_err_d = clamp_c;
    end else if (halt) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = next_frame_c ? '0 : (cnt_q + PERIOD_W'(1));
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      per_q     <= PERIOD_W'(MIN_FRAME);
      cnt_q     <= '0;
      run_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      per_q     <= per_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: rtl/ltc2324_acq_sequencer.sv
// LTC2324 acquisition sequencer: one CNV/conversion/SCK/latch frame every
// P clocks, continuous or N-frame burst, with graceful stop.
// Optional: define LTC2324_TIMESTAMP_EN to add the 8-bit frame_ts output.
module ltc2324_acq_sequencer
  import ltc2324_pkg::*;
#(
  parameter int unsigned PERIOD_W     = 16,
  parameter int unsigned CNV_HIGH_CYC = 3,
  parameter int unsigned CONV_CYC     = 45,
  parameter int unsigned SCK_BITS     = 16,
  parameter int unsigned DRAIN_CYC    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_count,
  output logic                busy,
  output logic                cnv_en,
  output logic                sck_gate,
  output logic                rx_start,
  output logic                data_latch,
  output logic [PERIOD_W-1:0] sample_cnt,
  output logic                done,
`ifdef LTC2324_TIMESTAMP_EN
  output logic [7:0]          frame_ts,
`endif
  output logic                cfg_err
);

  localparam int unsigned MIN_FRAME = min_frame(CNV_HIGH_CYC, CONV_CYC, SCK_BITS, DRAIN_CYC);
  // Phase counter must hold the longest phase length (CONV_CYC)
  localparam int unsigned PH_W      = 8;

  seq_state_e          state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] sample_cnt_q, sample_cnt_d;
  logic                stop_pend_q, stop_pend_d;
  logic                busy_q, busy_d;
  logic                cnv_en_q, cnv_en_d;
  logic                sck_gate_q, sck_gate_d;
  logic                rx_start_q, rx_start_d;
  logic                data_latch_q, data_latch_d;
  logic                done_q, done_d;
  logic                load_c, halt_c, end_c;
  logic                next_frame_c, stop_seen_c, burst_end_c;
`ifdef LTC2324_TIMESTAMP_EN
  logic [7:0]          frame_ts_q, frame_ts_d;
`endif

  ltc2324_frame_timer #(
    .PERIOD_W  (PERIOD_W),
    .MIN_FRAME (MIN_FRAME)
  ) u_frame_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (load_c),
    .halt         (halt_c),
    .cfg_period   (cfg_period),
    .next_frame_c (next_frame_c),
    .cfg_err      (cfg_err)
  );

  // Next-state, phase counting and registered-output decode
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    count_d      = count_q;
    sample_cnt_d = sample_cnt_q;
    stop_pend_d  = stop_pend_q;
    done_d       = 1'b0;
    load_c       = 1'b0;
    halt_c       = 1'b0;
    end_c        = 1'b0;
    stop_seen_c  = stop_pend_q | stop;
    burst_end_c  = (count_q != '0) && (sample_cnt_q == count_q);
`ifdef LTC2324_TIMESTAMP_EN
    frame_ts_d   = frame_ts_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_CNV;
          ph_d         = '0;
          count_d      = cfg_count;
          sample_cnt_d = '0;
          stop_pend_d  = 1'b0;
          load_c       = 1'b1;
`ifdef LTC2324_TIMESTAMP_EN
          frame_ts_d   = '0;
`endif
        end
      end
      ST_CNV: begin
        if (ph_q == PH_W'(CNV_HIGH_CYC - 1)) begin
          state_d = ST_CONV_WAIT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_CONV_WAIT: begin
        if (ph_q == PH_W'(CONV_CYC - 1)) begin
          state_d = ST_READ;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_READ: begin
        if (ph_q == PH_W'(SCK_BITS - 1)) begin
          state_d = ST_DRAIN;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ph_q == PH_W'(DRAIN_CYC - 1)) begin
          state_d = ST_LATCH;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_LATCH: begin
        // A minimum-length period has no HOLD cycles at all
        if (burst_end_c) begin
          end_c = 1'b1;
        end else if (next_frame_c) begin
          if (stop_seen_c) begin
            end_c = 1'b1;
          end else begin
            state_d = ST_CNV;
            ph_d    = '0;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (next_frame_c) begin
          if (stop_seen_c) begin
            end_c = 1'b1;
          end else begin
            state_d = ST_CNV;
            ph_d    = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
      end
    endcase

    if (end_c) begin
      state_d     = ST_IDLE;
      ph_d        = '0;
      done_d      = 1'b1;
      halt_c      = 1'b1;
      stop_pend_d = 1'b0;
    end

    // Stop never truncates a frame; it is remembered until the frame ends
    if (stop && (state_q != ST_IDLE) && !end_c) begin
      stop_pend_d = 1'b1;
    end

    if ((state_d == ST_LATCH) && (sample_cnt_q != {PERIOD_W{1'b1}})) begin
      sample_cnt_d = sample_cnt_q + PERIOD_W'(1);
    end
`ifdef LTC2324_TIMESTAMP_EN
    if (state_d == ST_LATCH) begin
      frame_ts_d = frame_ts_q + 8'd1;
    end
`endif

    busy_d       = (state_d != ST_IDLE);
    cnv_en_d     = (state_d == ST_CNV);
    sck_gate_d   = (state_d == ST_READ);
    rx_start_d   = (state_d == ST_CONV_WAIT) && (ph_d == PH_W'(CONV_CYC - 1));
    data_latch_d = (state_d == ST_LATCH);
  end

  // Sequencer state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ph_q         <= '0;
      count_q      <= '0;
      sample_cnt_q <= '0;
      stop_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      cnv_en_q     <= 1'b0;
      sck_gate_q   <= 1'b0;
      rx_start_q   <= 1'b0;
      data_latch_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef LTC2324_TIMESTAMP_EN
      frame_ts_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      count_q      <= count_d;
      sample_cnt_q <= sample_cnt_d;
      stop_pend_q  <= stop_pend_d;
      busy_q       <= busy_d;
      cnv_en_q     <= cnv_en_d;
      sck_gate_q   <= sck_gate_d;
      rx_start_q   <= rx_start_d;
      data_latch_q <= data_latch_d;
      done_q       <= done_d;
`ifdef LTC2324_TIMESTAMP_EN
      frame_ts_q   <= frame_ts_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign cnv_en     = cnv_en_q;
  assign sck_gate   = sck_gate_q;
  assign rx_start   = rx_start_q;
  assign data_latch = data_latch_q;
  assign sample_cnt = sample_cnt_q;
  assign done       = done_q;
`ifdef LTC2324_TIMESTAMP_EN
  assign frame_ts   = frame_ts_q;
`endif

endmodule
